// File: rtl/track_mixer.sv
// Sequential gain-weighted track mixer: snapshots one frame of track samples,
// accumulates one channel per cycle, then saturates the sum to the output word width.
module track_mixer #(
   parameter int WORD_WIDTH = 8,
   parameter int CHANNELS   = 8,
   parameter int GAIN_WIDTH = 3,
   parameter int GAIN_SHIFT = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [CHANNELS*WORD_WIDTH-1:0] samples,
   input  logic [CHANNELS*GAIN_WIDTH-1:0] gains,
   input  logic [CHANNELS-1:0]            mute,
   output logic [WORD_WIDTH-1:0]          mix_out,
   output logic                           mix_valid,
   output logic                           clip,
   output logic                           busy,
   output logic                           overrun
);

   localparam int CNT_W  = $clog2(CHANNELS);
   localparam int PROD_W = WORD_WIDTH + GAIN_WIDTH + 1;
   localparam int ACC_W  = WORD_WIDTH + GAIN_WIDTH + CNT_W + 1;
   localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-WORD_WIDTH+1){1'b0}}, {(WORD_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

   state_t                          state;
   state_t                          state_nxt;
   logic                            accept;
   logic [CNT_W-1:0]                cnt;
   logic signed [ACC_W-1:0]         acc;
   logic signed [ACC_W-1:0]         term;
   logic [CHANNELS*WORD_WIDTH-1:0]  samples_q;
   logic [CHANNELS*GAIN_WIDTH-1:0]  gains_q;
   logic [CHANNELS-1:0]             mute_q;
   logic signed [WORD_WIDTH-1:0]    smp_arr  [CHANNELS];
   logic [GAIN_WIDTH-1:0]           gain_arr [CHANNELS];

   // Gain is zero-extended so the product stays signed; >>> floors toward -inf.
   function automatic logic signed [ACC_W-1:0] scale_term(
      input logic signed [WORD_WIDTH-1:0] smp,
      input logic [GAIN_WIDTH-1:0]        gain
   );
      logic signed [PROD_W-1:0] smp_x;
      logic signed [PROD_W-1:0] gain_x;
      logic signed [PROD_W-1:0] prod;
      smp_x  = {{(GAIN_WIDTH+1){smp[WORD_WIDTH-1]}}, smp};
      gain_x = {{(WORD_WIDTH+1){1'b0}}, gain};
      prod   = smp_x * gain_x;
      prod   = prod >>> GAIN_SHIFT;
      return {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   endfunction

   // Returns {clip, word}.
   function automatic logic [WORD_WIDTH:0] saturate(
      input logic signed [ACC_W-1:0] a
   );
      if (a > SAT_MAX)
         return {1'b1, 1'b0, {(WORD_WIDTH-1){1'b1}}};
      else if (a < SAT_MIN)
         return {1'b1, 1'b1, {(WORD_WIDTH-1){1'b0}}};
      else
         return {1'b0, a[WORD_WIDTH-1:0]};
   endfunction

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         smp_arr[k]  = samples_q[k*WORD_WIDTH +: WORD_WIDTH];
         gain_arr[k] = gains_q[k*GAIN_WIDTH +: GAIN_WIDTH];
      end
   end

   always_comb begin
      term = '0;
      if (!mute_q[cnt])
         term = scale_term(smp_arr[cnt], gain_arr[cnt]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (cnt == LAST_CH)
               state_nxt = SAT;
         end
         SAT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Frame snapshot is pure data; it is only meaningful once a frame is accepted.
   always_ff @(posedge clk) begin
      if (accept) begin
         samples_q <= samples;
         gains_q   <= gains;
         mute_q    <= mute;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         acc       <= '0;
         mix_out   <= '0;
         clip      <= 1'b0;
         mix_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         if (start && state != IDLE)
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  acc <= '0;
                  cnt <= '0;
               end
            end
            ACCUM: begin
               acc <= acc + term;
               cnt <= cnt + CNT_W'(1);
            end
            SAT: begin
               {clip, mix_out} <= saturate(acc);
               mix_valid       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_track_mixer.sv
// Bench for track_mixer: table of frames with a latency-aware scoreboard,
// plus hand-written overrun, mid-frame reset and back-to-back sequences.
module tb_track_mixer;

   localparam int WW = 8;
   localparam int CH = 8;
   localparam int GW = 3;

   logic              clk;
   logic              rst;
   logic              start;
   logic [CH*WW-1:0]  samples;
   logic [CH*GW-1:0]  gains;
   logic [CH-1:0]     mute;
   logic [WW-1:0]     mix_out;
   logic              mix_valid;
   logic              clip;
   logic              busy;
   logic              overrun;

   track_mixer #(
      .WORD_WIDTH(WW), .CHANNELS(CH), .GAIN_WIDTH(GW), .GAIN_SHIFT(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .samples(samples), .gains(gains),
      .mute(mute), .mix_out(mix_out), .mix_valid(mix_valid), .clip(clip),
      .busy(busy), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         s [8];
      int         g [8];
      logic [7:0] m;
      int         eo;
      logic       ec;
   } vec_t;

   typedef struct {
      logic [7:0] out;
      logic       clp;
      int         due;
   } exp_t;

   vec_t vecs [13];
   exp_t sb [$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;
   int   busy_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // One clock; outputs sampled on the falling edge; scoreboard checked here.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      edge_n++;
      if (busy) busy_cnt++;
      if (mix_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_valid: mix_valid high with no frame pending (edge %0d)", edge_n);
         end else begin
            e = sb.pop_front();
            check("mix_out", 32'(mix_out), 32'(e.out));
            check("clip", 32'(clip), 32'(e.clp));
            check("latency_edge", 32'(edge_n), 32'(e.due));
         end
      end else if (sb.size() != 0 && edge_n > sb[0].due) begin
         n_checks++;
         n_fail++;
         $display("FAIL valid_timeout: no mix_valid by edge %0d, expected at %0d", edge_n, sb[0].due);
         void'(sb.pop_front());
      end
   endtask

   task automatic apply(input vec_t v);
      for (int k = 0; k < CH; k++) begin
         samples[k*WW +: WW] = 8'(v.s[k]);
         gains[k*GW +: GW]   = 3'(v.g[k]);
      end
      mute = v.m;
   endtask

   task automatic frame_start(input vec_t v);
      exp_t e;
      apply(v);
      e.out = 8'(v.eo);
      e.clp = v.ec;
      e.due = edge_n + 10;
      sb.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic scramble();
      samples = {$urandom(), $urandom()};
      gains   = 24'($urandom());
      mute    = 8'($urandom());
   endtask

   task automatic drain();
      int budget = 30;
      while (sb.size() != 0 && budget > 0) begin
         tick();
         budget--;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d frames still pending", sb.size());
         sb.delete();
      end
      repeat (3) tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_mix_out"}, 32'(mix_out), 32'h0);
      check({tag, "_mix_valid"}, 32'(mix_valid), 32'h0);
      check({tag, "_clip"}, 32'(clip), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_overrun"}, 32'(overrun), 32'h0);
   endtask

   initial begin
      vec_t v;
      vecs[0]  = '{'{10,0,0,0,0,0,0,0},           '{4,4,4,4,4,4,4,4}, 8'h00,   10, 1'b0};
      vecs[1]  = '{'{100,100,100,100,100,100,100,100}, '{4,4,4,4,4,4,4,4}, 8'h00, 127, 1'b1};
      vecs[2]  = '{'{-100,-100,-100,-100,-100,-100,-100,-100}, '{4,4,4,4,4,4,4,4}, 8'h00, -128, 1'b1};
      vecs[3]  = '{'{0,0,0,-7,0,20,50,0},         '{4,4,4,2,4,7,4,4}, 8'h40,   31, 1'b0};
      vecs[4]  = '{'{100,100,100,100,100,100,100,100}, '{4,4,4,4,4,4,4,4}, 8'hFF, 0, 1'b0};
      vecs[5]  = '{'{50,50,50,50,50,50,50,50},    '{0,0,0,0,0,0,0,0}, 8'h00,    0, 1'b0};
      vecs[6]  = '{'{-1,-1,0,0,0,0,0,0},          '{1,1,4,4,4,4,4,4}, 8'h00,   -2, 1'b0};
      vecs[7]  = '{'{127,0,0,0,0,0,0,0},          '{4,4,4,4,4,4,4,4}, 8'h00,  127, 1'b0};
      vecs[8]  = '{'{127,1,0,0,0,0,0,0},          '{4,4,4,4,4,4,4,4}, 8'h00,  127, 1'b1};
      vecs[9]  = '{'{-128,0,0,0,0,0,0,0},         '{4,4,4,4,4,4,4,4}, 8'h00, -128, 1'b0};
      vecs[10] = '{'{-128,-1,0,0,0,0,0,0},        '{4,4,4,4,4,4,4,4}, 8'h00, -128, 1'b1};
      vecs[11] = '{'{-128,-128,-128,-128,-128,-128,-128,-128}, '{7,7,7,7,7,7,7,7}, 8'h00, -128, 1'b1};
      vecs[12] = '{'{3,-5,7,0,0,0,0,99},          '{5,3,6,4,4,4,4,4}, 8'h80,    9, 1'b0};

      rst     = 1'b0;
      start   = 1'b0;
      samples = '0;
      gains   = '0;
      mute    = '0;
      #1;
      check_idle_outputs("reset");
      repeat (2) tick();
      rst = 1'b1;
      tick();

      // Table frames; inputs are scrambled one cycle after the strobe.
      foreach (vecs[i]) begin
         busy_cnt = 0;
         frame_start(vecs[i]);
         scramble();
         drain();
         check("busy_cycles", 32'(busy_cnt), 32'd9);
         check("overrun_clean", 32'(overrun), 32'h0);
      end

      // Second strobe three cycles into a frame is dropped and flagged.
      frame_start(vecs[3]);
      tick();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("overrun_set", 32'(overrun), 32'h1);
      check("busy_after_overrun", 32'(busy), 32'h1);
      scramble();
      drain();
      frame_start(vecs[0]);
      drain();
      check("overrun_sticky", 32'(overrun), 32'h1);

      // Asynchronous reset during the fourth accumulate cycle abandons the frame.
      frame_start(vecs[1]);
      repeat (3) tick();
      rst = 1'b0;
      #1;
      sb.delete();
      check_idle_outputs("midreset");
      repeat (3) tick();
      check("midreset_no_valid", 32'(mix_valid), 32'h0);
      rst = 1'b1;
      tick();
      v = vecs[0];
      v.s[0] = 5;
      v.eo   = 5;
      frame_start(v);
      drain();
      check("post_reset_overrun", 32'(overrun), 32'h0);
      check("post_reset_out", 32'(mix_out), 32'h05);

      // Back-to-back: new strobe on the cycle mix_valid is high.
      frame_start(vecs[3]);
      repeat (8) tick();
      check("b2b_valid_seen", 32'(mix_valid), 32'h0);
      tick();
      check("b2b_valid_high", 32'(mix_valid), 32'h1);
      frame_start(vecs[12]);
      scramble();
      drain();
      check("b2b_no_overrun", 32'(overrun), 32'h0);

      // Strobe held for three cycles: first accepted, the rest are overruns.
      apply(vecs[6]);
      begin
         exp_t e;
         e.out = 8'(vecs[6].eo);
         e.clp = vecs[6].ec;
         e.due = edge_n + 10;
         sb.push_back(e);
      end
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      drain();
      check("held_start_overrun", 32'(overrun), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
